mul_acc_sequencer: RTL
======================

Name: mul_acc_sequencer

Overview:
- FSM controller for the 8-bit accumulator/counter datapath. Computes an unsigned multiply A*B by repeated addition, modulo 2^8.
- Captures both operands on a start handshake, drives the datapath's data input and 5-bit ACC_Ctrl word each cycle, and watches the datapath's count-nonzero flag.
- Sits between the requesting host logic and the datapath instance; the only thing that sequences it.

Parameters:
- DATA_W, 8, operand/result width; must equal datapath width (only 8 supported).
- CTRL_HOLD, 5'b11000, ACC_Ctrl code: hold ACC and Count.
- CTRL_CLR, 5'b00000, ACC_Ctrl code: ACC<=0, Count<=0.
- CTRL_LDC, 5'b10110, ACC_Ctrl code: Count<=Count+Data_In, ACC held.
- CTRL_ADD, 5'b01111, ACC_Ctrl code: ACC<=ACC+Data_In, Count held.
- CTRL_DEC, 5'b10100, ACC_Ctrl code: Count<=Count+8'hFF (decrement), ACC held.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- abort  input  1  synchronous cancel of an operation in progress.
- op_a  input  DATA_W  multiplicand; sampled on accept.
- op_b  input  DATA_W  multiplier (iteration count); sampled on accept.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  DATA_W  product mod 256; held until next done.
- dp_data  output  DATA_W  drives datapath Data_In.
- dp_ctrl  output  5  drives datapath ACC_Ctrl.
- dp_acc  input  DATA_W  datapath ACC_Out.
- dp_cnt_nz  input  1  datapath Count_Reg_judge (Count != 0).

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, dp_ctrl=CTRL_HOLD, dp_data=0, operand registers=0.
- The datapath has no reset; the FSM always issues CLR before use.
- dp_ctrl and dp_data are registered, or a pure decode of state and operand registers. No combinational path from start/op_* to dp_*.
- States and per-state outputs:
  - IDLE: dp_ctrl=HOLD. start=1 -> latch op_a and op_b, go to CLEAR.
  - CLEAR: dp_ctrl=CLR. Go to LOAD.
  - LOAD: dp_ctrl=LDC, dp_data=op_b latched. Go to CHECK.
  - CHECK: dp_ctrl=HOLD. dp_cnt_nz=1 -> ADD; otherwise -> DONE.
  - ADD: dp_ctrl=ADD, dp_data=op_a latched. Go to DEC.
  - DEC: dp_ctrl=DEC. Go to CHECK.
  - DONE: dp_ctrl=HOLD, result<=dp_acc, done=1 for this cycle only. Go to IDLE.
- Latency: done is asserted in cycle 4+3*B after the accept edge (CLEAR is cycle 1).
  - B=0: 4 cycles. B=255: 769 cycles.
- Arithmetic: 8-bit wrap in the datapath; no overflow indication. result = (A*B) mod 256.
- start while busy: ignored; latched operands unchanged.
- start in the same cycle as DONE: ignored, because the FSM is not in IDLE. Host re-asserts start.
- abort (busy=1): next state IDLE, no done pulse, result unchanged, dp_ctrl=HOLD from next cycle. abort in IDLE has no effect.
- abort and start together in IDLE: start wins (abort is a no-op in IDLE).
- Reset mid-operation: immediate return to reset values. Any partial datapath contents are discarded by the next CLEAR.
- op_a and op_b may change freely after the accept cycle.

Test Plan:
- Reset, then A=5, B=3, start for 1 cycle -> busy for 13 cycles; done pulse in cycle 13; result=15; dp_ctrl sequence 00000,10110,11000,(01111,10100,11000)x3, then HOLD.
- A=7, B=0 -> CHECK exits immediately; done in cycle 4; result=0; dp_ctrl never equals 01111.
- A=20, B=20 -> result=144 (400 mod 256); done in cycle 64.
- A=1, B=255 -> result=255; done in cycle 769. Pulse start again with A=9, B=2 while busy -> ignored, first result unaffected.
- A=3, B=10, abort asserted in cycle 8 -> IDLE next cycle; no done pulse; result keeps the prior value. New start with A=2, B=2 -> result=4.
- Assert Reset in cycle 5 of A=4, B=6 -> busy=0, result=0, dp_ctrl=11000 next cycle. Following run A=4, B=6 -> result=24, with no residue from the interrupted run.

Source files
------------

// File: rtl/mul_acc_sequencer.sv
// mul_acc_sequencer: FSM that computes (A*B) mod 2^DATA_W by repeated
// addition on an external accumulator/counter datapath.
//
// Ports:
//   Clk, Reset      rising-edge clock, synchronous active-high reset
//   start, abort    host request (taken in IDLE) / cancel while busy
//   op_a, op_b      multiplicand / multiplier, captured on accept
//   busy, done      non-IDLE indicator / one-cycle result-valid pulse
//   result          product, held until the next done
//   dp_data         datapath Data_In
//   dp_ctrl         datapath ACC_Ctrl
//   dp_acc          datapath ACC_Out
//   dp_cnt_nz       datapath Count != 0 flag

module mul_acc_sequencer #(
   parameter int unsigned DATA_W    = 8,
   parameter logic [4:0]  CTRL_HOLD = 5'b11000,
   parameter logic [4:0]  CTRL_CLR  = 5'b00000,
   parameter logic [4:0]  CTRL_LDC  = 5'b10110,
   parameter logic [4:0]  CTRL_ADD  = 5'b01111,
   parameter logic [4:0]  CTRL_DEC  = 5'b10100
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] dp_data,
   output logic [4:0]        dp_ctrl,
   input  logic [DATA_W-1:0] dp_acc,
   input  logic              dp_cnt_nz
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_CHECK,
      S_ADD,
      S_DEC,
      S_DONE
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;

   // All outputs are registered: each branch sets the outputs that belong
   // to the state being entered, so dp_ctrl/dp_data never see start/op_*
   // combinationally.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         dp_data <= '0;
         dp_ctrl <= CTRL_HOLD;
      end else begin
         done    <= 1'b0;
         dp_data <= '0;
         dp_ctrl <= CTRL_HOLD;
         if (abort && (state != S_IDLE)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start) begin
                     a_q     <= op_a;
                     b_q     <= op_b;
                     state   <= S_CLEAR;
                     busy    <= 1'b1;
                     dp_ctrl <= CTRL_CLR;
                  end
               end
               S_CLEAR: begin
                  state   <= S_LOAD;
                  dp_ctrl <= CTRL_LDC;
                  dp_data <= b_q;
               end
               S_LOAD: begin
                  state <= S_CHECK;
               end
               S_CHECK: begin
                  // Count is the datapath register, so the flag already
                  // reflects the LDC or DEC issued two cycles earlier.
                  if (dp_cnt_nz) begin
                     state   <= S_ADD;
                     dp_ctrl <= CTRL_ADD;
                     dp_data <= a_q;
                  end else begin
                     // ACC is held in CHECK, so it is already final here.
                     state  <= S_DONE;
                     done   <= 1'b1;
                     result <= dp_acc;
                  end
               end
               S_ADD: begin
                  state   <= S_DEC;
                  dp_ctrl <= CTRL_DEC;
               end
               S_DEC: begin
                  state <= S_CHECK;
               end
               S_DONE: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
